// File: rtl/core_pkg.sv
// Shared core constants and types used by the fetch front end.
package core_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef logic [XLEN-1:0] instr_t;

endpackage : core_pkg

// File: rtl/fetch_queue.sv
// Parametrised synchronous FIFO with flush; write-then-visible, head always on data_o.
module fetch_queue #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer advance that also handles non power-of-two depths.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // A pop of an empty FIFO is ignored; a push into a full FIFO needs a matching pop.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Next-state pointers and occupancy; flush empties the FIFO.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = next_ptr(wptr_q);
            end
            if (do_pop) begin
                rptr_d = next_ptr(rptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, imem request tracking, in-order
// instruction queue to decode, and redirect handling that drops stale responses.
module fetch_unit #(
    parameter int unsigned    XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC),
    parameter int unsigned    QDEPTH   = 4,
    parameter int unsigned    MAX_OUT  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc
);

    import core_pkg::*;

    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned QC_W  = $clog2(QDEPTH + 1);
    localparam int unsigned SUM_W = $clog2(QDEPTH + MAX_OUT + 1) + 1;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [OUT_W-1:0]  drop_q, drop_d;
    logic [QC_W-1:0]   q_count;
    logic [2*XLEN-1:0] q_head;
    logic [OUT_W-1:0]  pf_count;
    logic [XLEN-1:0]   pf_head;
    logic              room_ok;
    logic              credit_ok;
    logic              acc;
    logic              resp_ok;
    logic              resp_live;
    logic              deq;

    // Issue only when the queue can absorb every live request and the credit limit allows.
    assign room_ok   = (SUM_W'(q_count) + SUM_W'(out_q)) < SUM_W'(QDEPTH);
    assign credit_ok = (SUM_W'(out_q) + SUM_W'(drop_q)) < SUM_W'(MAX_OUT);

    assign imem_req_valid = !reset && room_ok && credit_ok;
    assign imem_req_addr  = pc_q;

    assign acc       = imem_req_valid && imem_req_ready;
    assign resp_ok   = imem_resp_valid && (pf_count != '0);
    assign resp_live = resp_ok && (drop_q == '0);
    assign deq       = instr_valid && instr_ready;

    assign instr_valid = (q_count != '0);
    assign instr_data  = instr_valid ? q_head[2*XLEN-1:XLEN] : '0;
    assign instr_pc    = instr_valid ? q_head[XLEN-1:0]      : '0;

    // PC and request accounting; a redirect turns all live requests into drops.
    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q;
        drop_d = drop_q;
        if (acc) begin
            pc_d  = pc_q + XLEN'(4);
            out_d = out_q + OUT_W'(1);
        end
        if (resp_ok) begin
            if (drop_q != '0) begin
                drop_d = drop_q - OUT_W'(1);
            end else begin
                out_d = out_d - OUT_W'(1);
            end
        end
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~XLEN'(3);
            drop_d = drop_d + out_d;
            out_d  = '0;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    // PCs of issued requests, popped in order as responses return.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_pc_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (1'b0),
        .push_i  (acc),
        .data_i  (pc_q),
        .pop_i   (resp_ok),
        .data_o  (pf_head),
        .count_o (pf_count)
    );

    // Instruction queue of {instr, pc} in front of decode.
    fetch_queue #(
        .WIDTH (2 * XLEN),
        .DEPTH (QDEPTH)
    ) u_instr_q (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (resp_live && !redirect_valid),
        .data_i  ({imem_resp_data, pf_head}),
        .pop_i   (deq && !redirect_valid),
        .data_o  (q_head),
        .count_o (q_count)
    );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked every cycle against a request/queue-level reference model.
module tb_fetch_unit;

    localparam int unsigned QDEPTH   = 4;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [31:0] RST_PC   = 32'h4000_0000;

    logic        clk = 1'b1;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .QDEPTH   (QDEPTH),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    // Reference model: fetch PC, in-flight request PCs (oldest n_stale are discarded), decode queue.
    logic [31:0] m_pc;
    logic [31:0] inflight[$];
    int          n_stale;
    ent_t        iq[$];
    bit          m_known = 0;
    // Memory environment: pending responses in request order.
    pend_t       pend[$];
    int          lat_min = 1;
    int          lat_max = 1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit pred_rv(input logic rst);
        int live;
        live = inflight.size() - n_stale;
        return !rst && (iq.size() + live < int'(QDEPTH)) && (inflight.size() < int'(MAX_OUT));
    endfunction

    function automatic bit rbit(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model on the edge.
    task automatic step(input logic rst, input logic rrdy, input logic drdy,
                        input logic redir, input logic [31:0] tgt);
        bit          exp_rv, exp_iv, acc, resp, deq;
        logic [31:0] rpc;
        reset          = rst;
        imem_req_ready = rrdy;
        instr_ready    = drdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (rst) pend.delete();
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end

        @(negedge clk);
        exp_rv = pred_rv(rst);
        exp_iv = iq.size() > 0;
        if (m_known) begin
            chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
            chk("imem_req_addr",  imem_req_addr, m_pc);
            chk("instr_valid",    32'(instr_valid), 32'(exp_iv));
            chk("instr_pc",       instr_pc,   exp_iv ? iq[0].pc   : 32'h0);
            chk("instr_data",     instr_data, exp_iv ? iq[0].data : 32'h0);
        end

        acc  = exp_rv && rrdy;
        resp = imem_resp_valid;
        deq  = exp_iv && drdy;
        if (rst) begin
            m_known = 1;
            m_pc    = RST_PC;
            inflight.delete();
            n_stale = 0;
            iq.delete();
        end else begin
            if (deq) void'(iq.pop_front());
            if (resp && inflight.size() > 0) begin
                rpc = inflight.pop_front();
                void'(pend.pop_front());
                if (n_stale > 0) n_stale--;
                else if (!redir) iq.push_back('{mem_word(rpc), rpc});
            end
            if (acc) begin
                inflight.push_back(m_pc);
                pend.push_back('{m_pc, cyc + int'($urandom_range(lat_max, lat_min))});
                m_pc = m_pc + 32'd4;
            end
            if (redir) begin
                iq.delete();
                n_stale = inflight.size();
                m_pc    = tgt & 32'hFFFF_FFFC;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bit found;

        // Reset, then free-flowing fetch with single-cycle memory.
        lat_min = 1; lat_max = 1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 1, 1, 0, 0);

        // Decode stall: queue fills, requests stop, then drains in order.
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0);

        // Memory not ready: address held until a single accept.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);

        // Redirect with two requests outstanding; misaligned target.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && (inflight.size() - n_stale) != 2; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 32'h4000_0103);
        for (int i = 0; i < 14; i++) step(0, 1, 1, 0, 0);

        // Redirect coincident with a request accept and a dequeue.
        lat_min = 2; lat_max = 2;
        step(1, 1, 1, 0, 0);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            if (iq.size() > 0 && pred_rv(1'b0)) begin
                step(0, 1, 1, 1, 32'h4000_0200);
                found = 1;
                break;
            end
            step(0, 1, 0, 0, 0);
        end
        chk("combo_cycle_reached", 32'(found), 32'd1);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);

        // Address wrap at the top of the address space.
        lat_min = 1; lat_max = 2;
        step(0, 1, 1, 1, 32'hFFFF_FFF2);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);

        // Randomized traffic with stalls, variable latency and occasional redirects.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            step(0, rbit(75), rbit(65), rbit(3), $urandom);
        end

        // Reset mid-stream, then restart and run more random traffic.
        step(1, rbit(50), rbit(50), 0, 0);
        for (int i = 0; i < 200; i++) begin
            step(0, rbit(80), rbit(70), rbit(2), $urandom);
        end
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
